// File: rtl/otter_prog_pkg.sv
// Shared types and programmer-bus bit positions for the OTTER program loader.
package otter_prog_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, FLUSH, RELEASE} prog_state_t;

  localparam int unsigned PROG_BYTE_LSB = 0;
  localparam int unsigned PROG_STB_BIT  = 8;
  localparam int unsigned PROG_EN_BIT   = 9;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for one asynchronous bit, with rising/falling edge pulses
// taken against a one-cycle-delayed copy of the synchronized value.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sh;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      prev <= 1'b0;
    end else begin
      sh[0] <= d;
      for (int i = 1; i < STAGES; i++) sh[i] <= sh[i-1];
      prev <= sh[STAGES-1];
    end
  end

  assign q    = sh[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/prog_loader.sv
// Downloads a program from the external programmer into instruction memory, holding
// the MCU in reset meanwhile and pulsing its reset once the download completes.
module prog_loader
  import otter_prog_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned RST_PULSE   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [9:0]        PROG_DATA,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DIN,
  output logic              MCU_HOLD,
  output logic              MCU_RST,
  output logic              BUSY,
  output logic [ADDR_W:0]   WORD_CNT,
  output logic              OVF
);

  localparam int unsigned     CNT_W     = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

  prog_state_t       state_q, state_d;
  logic [1:0]        idx_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  pulse_q;

  logic stb_q, stb_rise, stb_fall;
  logic en_q, en_rise, en_fall;
  logic unused_edges;
  logic [7:0] byte_sh [SYNC_STAGES];
  logic [7:0] byte_s;

  sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (PROG_DATA[PROG_STB_BIT]),
    .q    (stb_q),
    .rise (stb_rise),
    .fall (stb_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_en_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (PROG_DATA[PROG_EN_BIT]),
    .q    (en_q),
    .rise (en_rise),
    .fall (en_fall)
  );

  assign unused_edges = ^{stb_q, stb_fall, en_fall};

  // Byte lanes only need synchronizing; the strobe protocol keeps them stable around edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) byte_sh[i] <= '0;
    end else begin
      byte_sh[0] <= PROG_DATA[PROG_BYTE_LSB +: 8];
      for (int i = 1; i < SYNC_STAGES; i++) byte_sh[i] <= byte_sh[i-1];
    end
  end

  assign byte_s = byte_sh[SYNC_STAGES-1];

  logic cap, full, pulse_done, emit;
  assign cap        = (state_q == LOAD) && stb_rise;
  assign full       = (cnt_q == MEM_WORDS);
  assign pulse_done = (pulse_q == CNT_W'(RST_PULSE - 1));
  assign emit       = (state_q == WRITE) || (state_q == FLUSH);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_rise) state_d = LOAD;
      // A strobe coinciding with the enable fall is captured first, then the flush rule applies.
      LOAD: begin
        if (cap && (idx_q == 2'd3))  state_d = WRITE;
        else if (!en_q)              state_d = (cap || (idx_q != 2'd0)) ? FLUSH : RELEASE;
      end
      WRITE:   state_d = en_q ? LOAD : RELEASE;
      FLUSH:   state_d = RELEASE;
      RELEASE: if (pulse_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MEM_WE   = emit && !full;
    MCU_HOLD = (state_q == LOAD) || emit;
    MCU_RST  = (state_q == RELEASE);
    BUSY     = (state_q != IDLE);
    MEM_ADDR = addr_q;
    MEM_DIN  = word_q;
    WORD_CNT = cnt_q;
    OVF      = ovf_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= '0;
    end else begin
      if ((state_q == IDLE) && en_rise) begin
        idx_q  <= '0;
        word_q <= '0;
        addr_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (cap) begin
        word_q[{idx_q, 3'b000} +: 8] <= byte_s;
        idx_q                        <= idx_q + 2'd1;
      end
      if (emit) begin
        idx_q  <= '0;
        word_q <= '0;
        if (full) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + (ADDR_W + 1)'(1);
          // Hold at the top word rather than wrapping back to zero.
          if (!(&addr_q)) addr_q <= addr_q + ADDR_W'(1);
        end
      end
      pulse_q <= (state_q == RELEASE) ? pulse_q + CNT_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: downloads are modelled as byte lists split
// into little-endian words; a monitor pops expected writes whenever MEM_WE is seen.
module tb_prog_loader;
  import otter_prog_pkg::*;

  localparam int unsigned AW = 2;
  localparam int unsigned RP = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [9:0]    PROG_DATA;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_DIN;
  logic          MCU_HOLD;
  logic          MCU_RST;
  logic          BUSY;
  logic [AW:0]   WORD_CNT;
  logic          OVF;

  prog_loader #(.ADDR_W(AW), .RST_PULSE(RP), .SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PROG_DATA (PROG_DATA),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DIN   (MEM_DIN),
    .MCU_HOLD  (MCU_HOLD),
    .MCU_RST   (MCU_RST),
    .BUSY      (BUSY),
    .WORD_CNT  (WORD_CNT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (RST === 1'b0 && MEM_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_expected", 64'(MEM_WE), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(MEM_ADDR), 64'(e.addr));
        chk("write_data", 64'(MEM_DIN), 64'(e.data));
        chk("hold_during_write", 64'(MCU_HOLD), 64'd1);
      end
    end
  end

  // Reference: bytes fill words LSB-first, a trailing partial word is zero-padded,
  // and only the first 2**AW words land in memory.
  task automatic expect_words(input bq_t b, output int cnt, output bit ovf);
    int nw;
    nw = (b.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.data = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < b.size()) e.data[8*k +: 8] = b[4*w+k];
      e.addr = AW'(w);
      if (w < (1 << AW)) exp_q.push_back(e);
    end
    cnt = (nw < (1 << AW)) ? nw : (1 << AW);
    ovf = (nw > (1 << AW));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop_en);
    @(negedge CLK);
    PROG_DATA[7:0]          = b;
    PROG_DATA[PROG_STB_BIT] = 1'b0;
    repeat (2) @(negedge CLK);
    PROG_DATA[PROG_STB_BIT] = 1'b1;
    if (drop_en) PROG_DATA[PROG_EN_BIT] = 1'b0;
    repeat (3) @(negedge CLK);
    PROG_DATA[PROG_STB_BIT] = 1'b0;
    if (!drop_en) repeat (3) @(negedge CLK);
  endtask

  task automatic start_load();
    @(negedge CLK);
    PROG_DATA[PROG_EN_BIT] = 1'b1;
    repeat (4) @(negedge CLK);
    chk("hold_in_load", 64'(MCU_HOLD), 64'd1);
    chk("busy_in_load", 64'(BUSY), 64'd1);
    chk("cnt_clear_on_load", 64'(WORD_CNT), 64'd0);
    chk("ovf_clear_on_load", 64'(OVF), 64'd0);
  endtask

  task automatic send_all(input bq_t b, input bit coincide);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], coincide && (i == b.size() - 1));
    if (!coincide || b.size() == 0) begin
      @(negedge CLK);
      PROG_DATA[PROG_EN_BIT] = 1'b0;
    end
  endtask

  task automatic end_checks(input int cnt, input bit ovf);
    int t, len;
    bit hold_seen;
    t = 0;
    while (MCU_RST !== 1'b1 && t < 60) begin
      @(negedge CLK);
      t++;
    end
    chk("release_seen", 64'(MCU_RST), 64'd1);
    len = 0;
    hold_seen = 1'b0;
    while (MCU_RST === 1'b1 && len < 20) begin
      if (MCU_HOLD !== 1'b0) hold_seen = 1'b1;
      len++;
      @(negedge CLK);
    end
    chk("rst_pulse_len", 64'(len), 64'(RP));
    chk("hold_low_in_release", 64'(hold_seen), 64'd0);
    chk("idle_busy", 64'(BUSY), 64'd0);
    chk("idle_hold", 64'(MCU_HOLD), 64'd0);
    chk("word_cnt", 64'(WORD_CNT), 64'(cnt));
    chk("ovf", 64'(OVF), 64'(ovf));
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic download(input bq_t b, input bit coincide);
    int cnt;
    bit ovf;
    expect_words(b, cnt, ovf);
    start_load();
    send_all(b, coincide);
    end_checks(cnt, ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    64'(MEM_WE),   64'd0);
    chk({tag, "_addr"},  64'(MEM_ADDR), 64'd0);
    chk({tag, "_din"},   64'(MEM_DIN),  64'd0);
    chk({tag, "_hold"},  64'(MCU_HOLD), 64'd0);
    chk({tag, "_mcurst"},64'(MCU_RST),  64'd0);
    chk({tag, "_busy"},  64'(BUSY),     64'd0);
    chk({tag, "_cnt"},   64'(WORD_CNT), 64'd0);
    chk({tag, "_ovf"},   64'(OVF),      64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    int cnt;
    bit ovf;
    logic [AW-1:0] a3;
    logic we_seq [4];

    RST       = 1'b1;
    PROG_DATA = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Basic two-word load
    b = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    download(b, 1'b0);

    // Partial word flushed on enable fall
    b = '{8'hAA, 8'hBB, 8'hCC};
    download(b, 1'b0);

    // Latency: fourth strobe detected in N, write in N+1, address bumps by N+2
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_words(b, cnt, ovf);
    start_load();
    for (int i = 0; i < 3; i++) send_byte(b[i], 1'b0);
    @(negedge CLK);
    PROG_DATA[7:0] = b[3];
    repeat (2) @(negedge CLK);
    PROG_DATA[PROG_STB_BIT] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      we_seq[k] = MEM_WE;
      if (k == 2) a3 = MEM_ADDR;
    end
    chk("lat_we_pattern", 64'({we_seq[0], we_seq[1], we_seq[2], we_seq[3]}), 64'b0010);
    chk("lat_addr_at_write", 64'(a3), 64'd0);
    chk("lat_addr_after", 64'(MEM_ADDR), 64'd1);
    PROG_DATA[PROG_STB_BIT] = 1'b0;
    repeat (3) @(negedge CLK);
    PROG_DATA[PROG_EN_BIT] = 1'b0;
    end_checks(cnt, ovf);

    // Reset mid-load, then restart with enable still high
    start_load();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reset_outputs("midrst");
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    expect_words(b, cnt, ovf);
    send_all(b, 1'b0);
    end_checks(cnt, ovf);

    // Overflow: 20 bytes into a 4-word memory, then a clean load clears OVF
    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    download(b, 1'b0);
    b = '{8'h01, 8'h02, 8'h03};
    download(b, 1'b0);

    // Final strobe coincides with enable fall on a full word
    b = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    download(b, 1'b1);

    // Empty download
    b = {};
    download(b, 1'b0);

    // Randomized downloads
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(0, 22);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      download(b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
